// File: rtl/spart_tx_queue_if.sv
// SPART control bus between the transmit queue (master) and the SPART control block (slave).
interface spart_tx_queue_if #(
    parameter int DATA_W = 24
);
    logic              chip_enable;
    logic              r_w;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data;
    logic              tx_rdy;
    logic              ack;

    modport master (
        output chip_enable, r_w, addr, data,
        input  tx_rdy, ack
    );

    modport slave (
        input  chip_enable, r_w, addr, data,
        output tx_rdy, ack
    );
endinterface

// File: rtl/spart_tx_queue.sv
// Transmit-word FIFO feeding the SPART control block one word per tx_rdy/ack handshake.
// Optional REQ timeout with retry is enabled by defining SPART_TXQ_TIMEOUT_EN.
module spart_tx_queue #(
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     count,
    output logic               ovf,
    input  logic               ovf_clr,
    output logic               busy,
`ifdef SPART_TXQ_TIMEOUT_EN
    output logic               timeout_err,
`endif
    spart_tx_queue_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
    logic [PTR_W:0]    count_reg;
    logic              full_reg, empty_reg, ovf_reg;
    logic              ce_reg, ce_next, rw_reg, rw_next;
    logic [DATA_W-1:0] data_reg;
    logic [1:0]        sync_reg;
    logic              tx_rdy_s;
    logic              push, pop, load;
`ifdef SPART_TXQ_TIMEOUT_EN
    logic [15:0]       timer_reg, timer_next;
    logic              timeout_reg, timeout_next;
`endif

    // tx_rdy comes from the slower SPART clock domain
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= bus.tx_rdy;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate
    assign tx_rdy_s = sync_reg[1];

    // full is the pre-edge value, so a simultaneous pop never admits a push into a full queue
    assign push        = wr_en & ~full_reg;
    assign wr_ptr_next = wr_ptr_reg + {{PTR_W{1'b0}}, push};
    assign rd_ptr_next = rd_ptr_reg + {{PTR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
    end

    always_comb begin
        state_next = state_reg;
        ce_next    = ce_reg;
        rw_next    = rw_reg;
        load       = 1'b0;
        pop        = 1'b0;
`ifdef SPART_TXQ_TIMEOUT_EN
        timer_next   = timer_reg;
        timeout_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                ce_next = 1'b0;
                rw_next = 1'b1;
                if (!empty_reg && tx_rdy_s) begin
                    load       = 1'b1;
                    ce_next    = 1'b1;
                    rw_next    = 1'b0;
                    state_next = REQ;
`ifdef SPART_TXQ_TIMEOUT_EN
                    timer_next = 16'd0;
`endif
                end
            end
            REQ: begin
                ce_next = 1'b1;
                rw_next = 1'b0;
                if (bus.ack) begin
                    pop        = 1'b1;
                    ce_next    = 1'b0;
                    rw_next    = 1'b1;
                    state_next = WAIT_RDY;
                end
`ifdef SPART_TXQ_TIMEOUT_EN
                // Abort leaves the head in place so the same word is offered again
                else if (timer_reg == 16'(TIMEOUT - 1)) begin
                    ce_next      = 1'b0;
                    rw_next      = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = WAIT_RDY;
                end else begin
                    timer_next = timer_reg + 16'd1;
                end
`endif
            end
            WAIT_RDY: begin
                ce_next = 1'b0;
                rw_next = 1'b1;
                if (tx_rdy_s) state_next = IDLE;
            end
            default: begin
                ce_next    = 1'b0;
                rw_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            ovf_reg    <= 1'b0;
            ce_reg     <= 1'b0;
            rw_reg     <= 1'b1;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= wr_ptr_next - rd_ptr_next;
            full_reg   <= (wr_ptr_next[PTR_W] != rd_ptr_next[PTR_W]) &&
                          (wr_ptr_next[PTR_W-1:0] == rd_ptr_next[PTR_W-1:0]);
            empty_reg  <= (wr_ptr_next == rd_ptr_next);
            ovf_reg    <= (wr_en && full_reg) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_reg);
            ce_reg     <= ce_next;
            rw_reg     <= rw_next;
            if (load) data_reg <= mem[rd_ptr_reg[PTR_W-1:0]];
        end
    end

`ifdef SPART_TXQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_reg   <= 16'd0;
            timeout_reg <= 1'b0;
        end else begin
            timer_reg   <= timer_next;
            timeout_reg <= timeout_next;
        end
    end
    assign timeout_err = timeout_reg;
`endif

    assign full            = full_reg;
    assign empty           = empty_reg;
    assign count           = count_reg;
    assign ovf             = ovf_reg;
    assign busy            = (state_reg != IDLE) || !empty_reg;
    assign bus.chip_enable = ce_reg;
    assign bus.r_w         = rw_reg;
    assign bus.addr        = 2'b00;
    assign bus.data        = data_reg;
endmodule

// File: tb/tb_spart_tx_queue.sv
// Scoreboard bench for spart_tx_queue: stimulus queues expected words, a monitor checks each offer.
module tb_spart_tx_queue;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
`ifdef SPART_TXQ_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 65535;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              ovf_clr = 1'b0;
    logic              tx_rdy = 1'b0;
    logic              ack_auto = 1'b0;
    logic              ack_manual = 1'b0;
    logic              auto_ack = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              full, empty, ovf, busy;
    logic [PTR_W:0]    count;
`ifdef SPART_TXQ_TIMEOUT_EN
    logic              timeout_err;
`endif

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];

    spart_tx_queue_if #(.DATA_W(DATA_W)) bus ();
    assign bus.tx_rdy = tx_rdy;
    assign bus.ack    = ack_auto | ack_manual;

    always #5 clk = ~clk;

    spart_tx_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf), .ovf_clr(ovf_clr),
        .busy(busy),
`ifdef SPART_TXQ_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'd0, n >= 400}, 32'd0);
    endtask

    // Monitor: every rising chip_enable is one offered word, compared against the scoreboard head
    initial begin : monitor
        logic prev_ce;
        logic [DATA_W-1:0] e;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ce = 1'b0;
            end else begin
                if (bus.chip_enable && !prev_ce) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req actual data=0x%06h required no request", bus.data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn offered data=0x%06h expected=0x%06h", bus.data, e);
                        check("req_data", 32'(bus.data), 32'(e));
                        check("req_r_w", {31'd0, bus.r_w}, 32'd0);
                        check("req_addr", {30'd0, bus.addr}, 32'd0);
                    end
                end
                prev_ce = bus.chip_enable;
            end
        end
    end

    // Responder: one-cycle ack as soon as a request is seen, when enabled
    initial begin : responder
        forever begin
            tick();
            if (ack_auto) ack_auto = 1'b0;
            else if (auto_ack && bus.chip_enable) ack_auto = 1'b1;
        end
    end

    initial begin : main
        int n;
        tx_rdy = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ce", {31'd0, bus.chip_enable}, 32'd0);
        check("rst_r_w", {31'd0, bus.r_w}, 32'd1);
        check("rst_addr", {30'd0, bus.addr}, 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // Single word latency and ack
        auto_ack = 1'b1;
        push(24'hABCDEF, 1'b1);
        check("lat_push_ce", {31'd0, bus.chip_enable}, 32'd0);
        check("lat_push_count", 32'(count), 32'd1);
        tick();
        check("lat_ce", {31'd0, bus.chip_enable}, 32'd1);
        check("lat_r_w", {31'd0, bus.r_w}, 32'd0);
        check("lat_data", 32'(bus.data), 32'hABCDEF);
        tick();
        check("ack_ce", {31'd0, bus.chip_enable}, 32'd0);
        check("ack_r_w", {31'd0, bus.r_w}, 32'd1);
        check("ack_empty", {31'd0, empty}, 32'd1);
        check("ack_count", 32'(count), 32'd0);
        wait_drain();

        // Fill with tx_rdy low, then overflow
        auto_ack = 1'b0;
        tx_rdy   = 1'b0;
        repeat (4) tick();
        for (int i = 1; i <= 8; i++) push(24'(i), 1'b1);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_ce", {31'd0, bus.chip_enable}, 32'd0);
        push(24'h000099, 1'b0);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        tick();
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, ovf}, 32'd0);

        // Drain in order, then a wrapping second batch
        tx_rdy   = 1'b1;
        auto_ack = 1'b1;
        wait_drain();
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) push(24'h000100 + 24'(i), 1'b1);
        wait_drain();

        // Simultaneous push and pop at count=4
        auto_ack = 1'b0;
        for (int i = 0; i < 4; i++) push(24'h000200 + 24'(i), 1'b1);
        check("pp_count_before", 32'(count), 32'd4);
        check("pp_ce_before", {31'd0, bus.chip_enable}, 32'd1);
        wr_en      = 1'b1;
        wr_data    = 24'h000204;
        exp_q.push_back(24'h000204);
        ack_manual = 1'b1;
        tick();
        wr_en      = 1'b0;
        ack_manual = 1'b0;
        check("pp_count_after", 32'(count), 32'd4);
        check("pp_ce_after", {31'd0, bus.chip_enable}, 32'd0);
        auto_ack = 1'b1;
        wait_drain();

        // Reset while a word is in flight
        auto_ack = 1'b0;
        for (int i = 0; i < 3; i++) push(24'h000300 + 24'(i), 1'b1);
        check("mid_count", 32'(count), 32'd3);
        check("mid_ce", {31'd0, bus.chip_enable}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_ce", {31'd0, bus.chip_enable}, 32'd0);
        check("mid_rst_r_w", {31'd0, bus.r_w}, 32'd1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        ack_manual = 1'b1;
        tick();
        ack_manual = 1'b0;
        check("late_ack_count", 32'(count), 32'd0);
        check("late_ack_ce", {31'd0, bus.chip_enable}, 32'd0);
        check("late_ack_empty", {31'd0, empty}, 32'd1);
        repeat (4) tick();

`ifdef SPART_TXQ_TIMEOUT_EN
        // No ack: abort after TIMEOUT REQ cycles, word stays queued and is re-offered
        push(24'h000400, 1'b1);
        exp_q.push_back(24'h000400);
        n = 0;
        while (!timeout_err && n < 60) begin
            tick();
            n++;
        end
        check("to_seen", {31'd0, timeout_err}, 32'd1);
        check("to_count", 32'(count), 32'd1);
        check("to_ce", {31'd0, bus.chip_enable}, 32'd0);
        tick();
        check("to_pulse", {31'd0, timeout_err}, 32'd0);
        auto_ack = 1'b1;
        wait_drain();
`endif
        n = 0;
        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
